// File: rtl/local_packet_assembler_pkg.sv
// Shared NoC parameters for the local ejection path: flit/packet geometry
// and the small assembler state type.
package local_packet_assembler_pkg;

    localparam int FLIT_SIZE        = 4;
    localparam int PACKET_SIZE      = 32;
    localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
    localparam int PKT_DEPTH        = 4;
    localparam int DROP_CNT_W       = 16;

    // Counter width able to index n items; never narrower than 1 bit.
    function automatic int log2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Assembler state is implied by flit_cnt: zero means no partial packet held.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } asm_state_e;

endpackage

// File: rtl/local_packet_assembler_packet_fifo.sv
// Synchronous first-word-fall-through FIFO holding completed spike packets.
// Pushes while full and pops while empty are ignored.
module packet_fifo
    import local_packet_assembler_pkg::*;
#(
    parameter int WIDTH = PACKET_SIZE,
    parameter int DEPTH = PKT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, wrapping pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/local_packet_assembler.sv
// Router local-port ejection stage: gathers FLIT_SIZE-bit flits (low slice
// first) into PACKET_SIZE-bit packets, buffers them for the neuron core and
// back-pressures the router with o_full. Flits arriving while full are
// dropped and counted. PACKET_SIZE must be at least two flits.
module local_packet_assembler
    import local_packet_assembler_pkg::*;
#(
    parameter int PACKET_SIZE = local_packet_assembler_pkg::PACKET_SIZE,
    parameter int FLIT_SIZE   = local_packet_assembler_pkg::FLIT_SIZE,
    parameter int DEPTH       = PKT_DEPTH,
    parameter int CNT_W       = DROP_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLIT_SIZE-1:0]   i_flit_in,
    input  logic                   i_write_req,
    output logic                   o_full,
    output logic [PACKET_SIZE-1:0] o_packet_out,
    output logic                   o_packet_valid,
    input  logic                   i_packet_read,
    output logic                   o_assembling,
    output logic [CNT_W-1:0]       o_drop_count
);

    localparam int FPP = PACKET_SIZE / FLIT_SIZE;
    localparam int CW  = log2w(FPP);

    logic [CW-1:0]          r_flit_cnt;
    logic [PACKET_SIZE-1:0] r_shift;
    logic [CNT_W-1:0]       r_drop_count;
    logic                   w_fifo_full;
    logic [$clog2(DEPTH):0] w_pkt_count;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_push;
    logic [PACKET_SIZE-1:0] w_packet;
    asm_state_e             w_state;

    assign w_state  = (r_flit_cnt == '0) ? ST_IDLE : ST_ASSEMBLE;
    assign w_accept = i_write_req && !w_fifo_full;
    assign w_last   = (r_flit_cnt == CW'(FPP - 1));
    assign w_push   = w_accept && w_last;
    // Flits enter at the top and shift down, so the first flit ends at bits [FLIT_SIZE-1:0].
    assign w_packet = {i_flit_in, r_shift[PACKET_SIZE-1:FLIT_SIZE]};

    assign o_full         = w_fifo_full;
    assign o_packet_valid = (w_pkt_count != '0);
    assign o_assembling   = (w_state == ST_ASSEMBLE);
    assign o_drop_count   = r_drop_count;

    // Assembler: shift in accepted flits and wrap the flit counter on the completing flit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit_cnt <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_shift    <= w_packet;
            r_flit_cnt <= w_last ? '0 : r_flit_cnt + 1'b1;
        end
    end

    // Saturating count of flits the router pushed into a full buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (i_write_req && w_fifo_full && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    packet_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_packet),
        .i_pop   (i_packet_read),
        .o_data  (o_packet_out),
        .o_count (w_pkt_count),
        .o_full  (w_fifo_full)
    );

endmodule

// File: tb/tb_local_packet_assembler.sv
// Scoreboard bench for local_packet_assembler: stimulus appends expected
// packets to a queue, a reader/monitor pops and compares the FIFO head, and a
// per-cycle model of buffer occupancy and drop count checks the status outputs.
module tb_local_packet_assembler;

    localparam int DEPTH = 4;
    localparam int FPP   = 8;

    logic        clk = 0;
    logic        reset = 1;
    logic [3:0]  i_flit_in = '0;
    logic        i_write_req = 0;
    logic        o_full;
    logic [31:0] o_packet_out;
    logic        o_packet_valid;
    logic        i_packet_read = 0;
    logic        o_assembling;
    logic [15:0] o_drop_count;

    local_packet_assembler dut (
        .clk            (clk),
        .reset          (reset),
        .i_flit_in      (i_flit_in),
        .i_write_req    (i_write_req),
        .o_full         (o_full),
        .o_packet_out   (o_packet_out),
        .o_packet_valid (o_packet_valid),
        .i_packet_read  (i_packet_read),
        .o_assembling   (o_assembling),
        .o_drop_count   (o_drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  m_flits[$];
    int          m_cnt  = 0;
    int          m_drop = 0;
    bit          s_push = 0, s_drop = 0, m_pop = 0;
    int          rd_pct = 0;
    bit          rd_once = 0;
    int          n_pop = 0, n_push = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_flits();
        logic [31:0] p = '0;
        foreach (m_flits[i]) p = p | (32'(m_flits[i]) << (4 * i));
        return p;
    endfunction

    // One cycle of router-side stimulus; the model decides acceptance from its own occupancy.
    task automatic drive(input bit req, input logic [3:0] f);
        @(negedge clk);
        i_write_req = req;
        i_flit_in   = f;
        s_push = 0;
        s_drop = 0;
        if (req) begin
            if (m_cnt == DEPTH) s_drop = 1;
            else begin
                m_flits.push_back(f);
                if (m_flits.size() == FPP) begin
                    exp_q.push_back(pack_flits());
                    m_flits.delete();
                    s_push = 1;
                    n_push++;
                end
            end
        end
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] p);
        for (int i = 0; i < FPP; i++) drive(1'b1, p[4*i +: 4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        i_write_req = 0;
        s_push = 0;
        s_drop = 0;
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    task automatic drain();
        int i;
        rd_pct = 100;
        i = 0;
        while ((m_cnt != 0 || exp_q.size() != 0) && i < 64) begin
            drive(1'b0, 4'h0);
            i++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        rd_pct = 0;
    endtask

    // Reader / monitor: compare the presented head, then randomly pop it.
    always @(negedge clk) begin
        bit rd;
        if (m_cnt > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_underflow actual=valid expected=empty t=%0t", $time);
            end else chk("packet_out", o_packet_out, exp_q[0]);
        end
        rd = rd_once || ($urandom_range(99) < rd_pct);
        rd_once = 0;
        i_packet_read = rd;
        m_pop = rd && (m_cnt > 0);
        if (m_pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_pop++;
        end
    end

    // Occupancy / drop model advanced after every edge, then status outputs compared.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_cnt = 0;
            m_drop = 0;
            m_flits.delete();
            exp_q.delete();
            chk("rst_packet_out", o_packet_out, 32'h0);
        end else begin
            m_cnt = m_cnt + int'(s_push) - int'(m_pop);
            if (s_drop && m_drop != 16'hFFFF) m_drop++;
        end
        chk("full",         32'(o_full),         32'(m_cnt == DEPTH));
        chk("packet_valid", 32'(o_packet_valid), 32'(m_cnt != 0));
        chk("assembling",   32'(o_assembling),   32'(m_flits.size() != 0));
        chk("drop_count",   32'(o_drop_count),   32'(m_drop));
    end

    initial begin
        logic [31:0] p2;
        int np0;
        do_reset();

        // 1: flits 0..7 assemble low-nibble first
        for (int i = 0; i < FPP; i++) drive(1'b1, 4'(i));
        drive(1'b0, 4'h0);
        chk("t1_packet", o_packet_out, 32'h76543210);
        chk("t1_valid", 32'(o_packet_valid), 32'd1);
        chk("t1_assembling", 32'(o_assembling), 32'd0);

        // 2: fill the buffer, then a protocol-violating flit is dropped
        for (int k = 1; k < DEPTH; k++) send_pkt($urandom);
        drive(1'b0, 4'h0);
        chk("t2_full", 32'(o_full), 32'd1);
        drive(1'b1, 4'hF);
        drive(1'b0, 4'h0);
        chk("t2_drop", 32'(o_drop_count), 32'd1);
        chk("t2_not_assembling", 32'(o_assembling), 32'd0);

        // 3: single pop frees a slot; a new packet lands at the tail
        rd_once = 1;
        drive(1'b0, 4'h0);
        drive(1'b0, 4'h0);
        chk("t3_full_clear", 32'(o_full), 32'd0);
        send_pkt($urandom);
        drain();

        // 4: reset mid-packet discards the partial packet
        np0 = n_pop;
        for (int i = 0; i < 3; i++) drive(1'b1, 4'($urandom));
        do_reset();
        send_pkt(32'hA5A5A5A5);
        drive(1'b0, 4'h0);
        chk("t4_packet", o_packet_out, 32'hA5A5A5A5);
        drain();
        chk("t4_delivered", 32'(n_pop - np0), 32'd1);

        // 5: completion and pop on the same edge
        send_pkt(32'h1234ABCD);
        p2 = $urandom;
        for (int i = 0; i < FPP - 1; i++) drive(1'b1, p2[4*i +: 4]);
        rd_once = 1;
        drive(1'b1, p2[31:28]);
        drive(1'b0, 4'h0);
        chk("t5_head", o_packet_out, p2);
        chk("t5_valid", 32'(o_packet_valid), 32'd1);
        drain();

        // 6: long random run honouring back-pressure
        np0 = n_push;
        while (n_push - np0 < 1000) begin
            if (($urandom_range(7) == 0)) rd_pct = $urandom_range(10, 95);
            if (m_cnt == DEPTH || $urandom_range(9) == 0) drive(1'b0, 4'h0);
            else drive(1'b1, 4'($urandom));
        end
        drain();
        chk("t6_drop_zero", 32'(o_drop_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
